// File: rtl/vmicro16_apb_master_pkg.sv
// Shared SoC configuration for the vmicro16 APB master: bus widths and FSM state encoding.
package vmicro16_apb_master_pkg;

    localparam int unsigned APB_WIDTH      = 20;
    localparam int unsigned BUS_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2
    } apb_state_e;

endpackage

// File: rtl/vmicro16_apb_master.sv
// Single-outstanding APB master: turns a core request into one SETUP/ACCESS transfer and
// returns a one-cycle response strobe, with an optional ACCESS-phase wait timeout.
module vmicro16_apb_master
    import vmicro16_apb_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = APB_WIDTH,
    parameter int unsigned DATA_WIDTH = BUS_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,

    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,

    output logic [ADDR_WIDTH-1:0] M_PADDR,
    output logic                  M_PWRITE,
    output logic                  M_PSELx,
    output logic                  M_PENABLE,
    output logic [DATA_WIDTH-1:0] M_PWDATA,
    input  logic [DATA_WIDTH-1:0] M_PRDATA,
    input  logic                  M_PREADY
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    apb_state_e            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        rdata_d      = rdata_q;
        err_d        = err_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                cnt_d   = '0;
                state_d = StAccess;
            end
            StAccess: begin
                // PREADY is checked first so a completion beats a simultaneous timeout.
                if (M_PREADY) begin
                    state_d      = StIdle;
                    resp_valid_d = 1'b1;
                    rdata_d      = M_PRDATA;
                    err_d        = 1'b0;
                end else if (TIMEOUT != 0) begin
                    if (cnt_inc == CntW'(TIMEOUT)) begin
                        state_d      = StIdle;
                        resp_valid_d = 1'b1;
                        rdata_d      = '0;
                        err_d        = 1'b1;
                        cnt_d        = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign M_PSELx    = (state_q == StSetup) || (state_q == StAccess);
    assign M_PENABLE  = (state_q == StAccess);
    assign M_PADDR    = addr_q;
    assign M_PWRITE   = we_q;
    assign M_PWDATA   = wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: doc/vmicro16_apb_master.md
VMICRO16_APB_MASTER -- requirements
Module: vmicro16_apb_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default `APB_WIDTH (20), APB address width including the LWEX/SWEX/CORE_ID sideband bits.
REQ-002 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH (16), width of the data bus.
REQ-003 SHALL have parameter TIMEOUT, default 255, ACCESS-phase wait-cycle limit; 0 disables the timeout.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port req_valid, input, 1, core requests a bus transfer.
REQ-007 SHALL have port req_we, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port req_addr, input, ADDR_WIDTH, transfer address including sideband bits.
REQ-009 SHALL have port req_wdata, input, DATA_WIDTH, write data.
REQ-010 SHALL have port req_ready, output, 1, request accepted this cycle when high together with req_valid.
REQ-011 SHALL have port resp_valid, output, 1, one-cycle response strobe.
REQ-012 SHALL have port resp_rdata, output, DATA_WIDTH, read data or SWEX status.
REQ-013 SHALL have port resp_err, output, 1, transfer ended by timeout.
REQ-014 SHALL have APB master ports M_PADDR [ADDR_WIDTH], M_PWRITE, M_PSELx, M_PENABLE and M_PWDATA [DATA_WIDTH] as outputs, and M_PRDATA [DATA_WIDTH] and M_PREADY as inputs.

Function
REQ-015 SHALL implement the FSM IDLE -> SETUP -> ACCESS -> IDLE.
REQ-016 SHALL drive req_ready high only in IDLE; req_valid && req_ready captures req_we, req_addr and req_wdata into holding registers; next state is SETUP.
REQ-017 In SETUP: M_PSELx=1, M_PENABLE=0, for exactly one cycle; next state is ACCESS.
REQ-018 In ACCESS: M_PSELx=1, M_PENABLE=1; the block SHALL remain in ACCESS while M_PREADY=0.
REQ-019 M_PADDR, M_PWRITE and M_PWDATA SHALL come from the holding registers and stay stable from SETUP through the last ACCESS cycle.
REQ-020 M_PREADY=1 in ACCESS SHALL cause, on the next edge: state IDLE, resp_valid=1 for exactly one cycle, resp_rdata<=M_PRDATA for reads and writes alike (so SWEX status returns), resp_err=0.
REQ-021 The wait counter SHALL clear on entering ACCESS and increment on each ACCESS cycle with M_PREADY=0; when it equals TIMEOUT (TIMEOUT!=0) the block SHALL go to IDLE with resp_valid=1, resp_err=1 and resp_rdata=0.
REQ-022 If M_PREADY=1 arrives in the same cycle the count reaches TIMEOUT, the PREADY completion SHALL win (resp_err=0).
REQ-023 Outside SETUP and ACCESS, M_PSELx=0 and M_PENABLE=0; minimum transfer latency is 3 cycles from acceptance to resp_valid.
REQ-024 A new request MAY be accepted in the same IDLE cycle in which resp_valid is high; back-to-back transfers SHALL therefore sustain one transfer every 3 cycles.
REQ-025 resp_rdata and resp_err SHALL hold their values until the next response.
REQ-026 M_PRDATA SHALL be ignored outside ACCESS with M_PREADY=1.
REQ-027 The wait counter SHALL be wide enough for TIMEOUT and SHALL not wrap.

Reset
REQ-028 reset=0 at a clock edge SHALL force, regardless of state including mid-ACCESS: state IDLE, M_PSELx=0, M_PENABLE=0, M_PWRITE=0, M_PADDR=0, M_PWDATA=0, resp_valid=0, resp_err=0, resp_rdata=0, wait counter 0.
REQ-029 A transfer aborted by reset SHALL produce no response.

Structure
REQ-030 FSM state encodings SHALL be localparams in vmicro16_soc_config.v; APB_WIDTH and DATA_WIDTH SHALL come from the same file.
REQ-031 The design SHALL be a single module with no sub-modules.

Verification
REQ-032 Read, slave with PREADY tied high, M_PRDATA=16'hBEEF -> SETUP at cycle 1, ACCESS at cycle 2, resp_valid at cycle 3 with resp_rdata=16'hBEEF and resp_err=0.
REQ-033 Write addr 20'h0_0042, data 16'h1234, slave inserts 4 wait states -> M_PADDR and M_PWDATA stable across all 5 ACCESS cycles, a single resp_valid pulse.
REQ-034 TIMEOUT=8, PREADY held low -> resp_valid with resp_err=1 and resp_rdata=0 after 8 wait cycles; PSEL low on the following cycle.
REQ-035 SWEX write (addr bit 18 set), slave returns 16'h0001 -> resp_rdata=16'h0001.
REQ-036 reset=0 asserted during ACCESS -> PSEL/PENABLE low next cycle, no resp_valid; a following request completes normally.
REQ-037 req_valid held high for 3 requests -> accepted every 3 cycles; exactly 3 resp_valid pulses, in order.
